// File: rtl/recurrence_sequencer.sv
// recurrence_sequencer
//   Runs ITER iterations of a four-step recurrence on registers a/b/c/d:
//     a = b + c;  d = a - D_OFFSET;  b = d + B_OFFSET;  c = c + C_INC
//   Each step waits STEP_CYCLES clocks before it updates. All arithmetic is
//   modulo 2^WIDTH.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   start, abort           job request (sampled in IDLE) / terminate running job
//   a_in..d_in             initial values, captured on the accept edge
//   a, b, c, d             working registers
//   busy, done             job running / one-cycle completion pulse
//   step                   current step (0=a, 1=d, 2=b, 3=c)
//   iter_cnt               iterations completed in the current or last job
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | no job; outputs hold, waits for start
// RUN   | job active; step timer running, busy high
module recurrence_sequencer #(
  parameter int WIDTH       = 16,
  parameter int ITER        = 4,
  parameter int STEP_CYCLES = 5,
  parameter int D_OFFSET    = 3,
  parameter int B_OFFSET    = 10,
  parameter int C_INC       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [WIDTH-1:0]            a_in,
  input  logic [WIDTH-1:0]            b_in,
  input  logic [WIDTH-1:0]            c_in,
  input  logic [WIDTH-1:0]            d_in,
  output logic [WIDTH-1:0]            a,
  output logic [WIDTH-1:0]            b,
  output logic [WIDTH-1:0]            c,
  output logic [WIDTH-1:0]            d,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  step,
  output logic [$clog2(ITER+1)-1:0]   iter_cnt
);

  localparam int IW = $clog2(ITER + 1);
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [WIDTH-1:0] D_OFF     = WIDTH'(D_OFFSET);
  localparam logic [WIDTH-1:0] B_OFF     = WIDTH'(B_OFFSET);
  localparam logic [WIDTH-1:0] C_STEP    = WIDTH'(C_INC);
  localparam logic [IW-1:0]    ITER_LAST = IW'(ITER);
  // Step timer counts down; terminal count (zero) is the update edge.
  localparam logic [CW-1:0]    WAIT_INIT = CW'(STEP_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  a_n, b_n, c_n, d_n;
  logic              busy_n, done_n;
  logic [1:0]        step_n;
  logic [IW-1:0]     iter_n;
  logic [CW-1:0]     wcnt, wcnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      d        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step     <= '0;
      iter_cnt <= '0;
      wcnt     <= '0;
    end else begin
      state    <= state_n;
      a        <= a_n;
      b        <= b_n;
      c        <= c_n;
      d        <= d_n;
      busy     <= busy_n;
      done     <= done_n;
      step     <= step_n;
      iter_cnt <= iter_n;
      wcnt     <= wcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    c_n     = c;
    d_n     = d;
    busy_n  = busy;
    done_n  = 1'b0;
    step_n  = step;
    iter_n  = iter_cnt;
    wcnt_n  = wcnt;

    case (state)
      IDLE: begin
        // abort beats start in IDLE: nothing is loaded
        if (start && !abort) begin
          state_n = RUN;
          a_n     = a_in;
          b_n     = b_in;
          c_n     = c_in;
          d_n     = d_in;
          step_n  = 2'd0;
          iter_n  = '0;
          wcnt_n  = WAIT_INIT;
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          // registers freeze; any update due on this edge is dropped
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (wcnt == '0) begin
          wcnt_n = WAIT_INIT;
          step_n = step + 2'd1;
          case (step)
            2'd0: a_n = b + c;
            2'd1: d_n = a - D_OFF;
            2'd2: b_n = d + B_OFF;
            default: begin
              c_n    = c + C_STEP;
              iter_n = iter_cnt + IW'(1);
              if (iter_n == ITER_LAST) begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
              end
            end
          endcase
        end else begin
          wcnt_n = wcnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_recurrence_sequencer.sv
// Testbench for recurrence_sequencer (default parameters).
// Driver issues jobs and pushes the expected completion into a scoreboard;
// a negedge monitor pops and compares whenever done is seen.
module tb_recurrence_sequencer;

  localparam int W    = 16;
  localparam int ITER = 4;
  localparam int S    = 5;
  localparam int LAT  = 4 * ITER * S;

  typedef struct {
    logic [W-1:0] a, b, c, d;
  } regs_t;

  typedef struct {
    regs_t r;
    int    iters;
    int    done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [W-1:0] a_in, b_in, c_in, d_in;
  logic [W-1:0] a, b, c, d;
  logic         busy, done;
  logic [1:0]   step;
  logic [2:0]   iter_cnt;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  recurrence_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .step(step), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Apply the first n step updates of the recurrence, in spec order.
  function automatic regs_t model(input regs_t r0, input int n);
    regs_t r = r0;
    for (int k = 0; k < n; k++) begin
      case (k % 4)
        0: r.a = r.b + r.c;
        1: r.d = r.a - W'(3);
        2: r.b = r.d + W'(10);
        default: r.c = r.c + W'(1);
      endcase
    end
    return r;
  endfunction

  task automatic chk_regs(input string nm, input regs_t e);
    chk({nm, "_a"}, a, e.a);
    chk({nm, "_b"}, b, e.b);
    chk({nm, "_c"}, c, e.c);
    chk({nm, "_d"}, d, e.d);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
    @(negedge clk);
  endtask

  // Issue one job; abort_at = 0 means run to completion, else abort at edge t0+abort_at.
  task automatic run_job(input logic [W-1:0] ai, bi, ci, di, input int abort_at);
    regs_t r0, rm;
    exp_t  e;
    int    t0, n;
    r0 = '{a: ai, b: bi, c: ci, d: di};
    a_in = ai; b_in = bi; c_in = ci; d_in = di;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    chk("accept_busy", busy, 1);
    if (abort_at == 0) begin
      e.r = model(r0, 4 * ITER);
      e.iters = ITER;
      e.done_cyc = t0 + LAT;
      sb.push_back(e);
      wait_idle();
    end else begin
      repeat (abort_at - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n  = (abort_at - 1) / S;
      rm = model(r0, n);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk_regs("abort", rm);
      chk("abort_step", step, n % 4);
      chk("abort_iter", iter_cnt, n / 4);
      repeat (3) @(negedge clk);
      chk_regs("abort_hold", rm);
      chk("abort_hold_busy", busy, 0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      chk("done_not_busy", busy, 0);
      chk("done_one_cycle", prev_done, 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (cyc %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("done_iter", iter_cnt, e.iters);
        chk_regs("done", e.r);
      end
    end
    prev_done = done;
  end

  initial begin
    regs_t r;
    exp_t  e;
    int    t0, s0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    repeat (3) @(negedge clk);
    chk_regs("reset", '{a: 0, b: 0, c: 0, d: 0});
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_step", step, 0);
    chk("reset_iter", iter_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // abort alone and start+abort in IDLE: nothing happens
    a_in = 16'd7; b_in = 16'd8; c_in = 16'd9; d_in = 16'd10;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk_regs("idle_abort", '{a: 0, b: 0, c: 0, d: 0});

    // Directed default job with first-iteration snapshot
    a_in = 16'd30; b_in = 16'd20; c_in = 16'd15; d_in = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    e.r = '{a: 16'd107, b: 16'd114, c: 16'd19, d: 16'd104};
    e.iters = 4;
    e.done_cyc = t0 + 80;
    sb.push_back(e);
    repeat (20) @(negedge clk);
    chk_regs("iter1", '{a: 16'd35, b: 16'd42, c: 16'd16, d: 16'd32});
    chk("iter1_cnt", iter_cnt, 1);
    wait_idle();

    // Abort with step 3 of the first iteration pending
    run_job(16'd30, 16'd20, 16'd15, 16'd5, 17);
    chk_regs("abort17", '{a: 16'd35, b: 16'd42, c: 16'd15, d: 16'd32});
    // Abort on the would-be done edge: no done
    run_job(16'd1, 16'd2, 16'd3, 16'd4, LAT);

    // Wrap cases: overflow on a, underflow on d
    run_job(16'd0, 16'hFFFA, 16'd10, 16'd0, 0);
    run_job(16'd0, 16'd0, 16'd1, 16'd0, 0);

    // Randomized jobs
    for (int j = 0; j < 10; j++) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, LAT) : 0;
      run_job(W'($urandom), W'($urandom), W'($urandom), W'($urandom), ab);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // start held high: back-to-back jobs, each loaded one edge after done
    a_in = W'($urandom); b_in = W'($urandom); c_in = W'($urandom); d_in = W'($urandom);
    r = model('{a: a_in, b: b_in, c: c_in, d: d_in}, 4 * ITER);
    start = 1'b1;
    s0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e.r = r;
      e.iters = ITER;
      e.done_cyc = s0 + k * (LAT + 1) + LAT;
      sb.push_back(e);
    end
    repeat (200) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-job: all zero next cycle, no done
    a_in = 16'd30; b_in = 16'd20; c_in = 16'd15; d_in = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_regs("midreset", '{a: 0, b: 0, c: 0, d: 0});
    chk("midreset_busy", busy, 0);
    chk("midreset_iter", iter_cnt, 0);
    repeat (LAT + 5) @(negedge clk);
    chk("midreset_done", done, 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
